pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Controls the reset and lock sequence of the core PLL (50 MHz reference in, 40/20 MHz out).
- Pulses the PLL reset and waits for `locked` to be stable before releasing the downstream core reset.
- Retries the PLL on lock timeout and reports permanent failure.
- Re-runs the whole sequence on lock loss or on a host re-lock request (e.g. after a mode change). Sits in the sys layer, clocked from the free-running reference clock.

Parameters:
- RST_PULSE, 16: cycles `pll_rst` is held high per attempt (>=2).
- LOCK_STABLE, 1024: consecutive synced-locked cycles required before release (>=2).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before retry (>=2).
- MAX_RETRIES, 3: retries after the first attempt before ERROR (0..15).

Ports:
- refclk  in  1  free-running reference clock; all logic in this domain.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL lock indicator; asynchronous to refclk.
- relock_req  in  1  single-cycle pulse requesting a full re-lock sequence.
- pll_rst  out  1  reset to the PLL.
- core_rst  out  1  active-high reset to all PLL-clocked logic.
- ready  out  1  high only in RUN.
- lock_err  out  1  high only in ERROR.
- retry_cnt  out  4  retries used in the current sequence.
- state_dbg  out  3  encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, ERROR=4.

Behaviour:
- `locked` passes through a 2-flop synchronizer to give `locked_s`. The synchronizer flops clear on `rst`.
- Single counter `cnt`. Width is clog2 of the maximum of RST_PULSE, LOCK_STABLE and LOCK_TIMEOUT. It clears to 0 on every state change.
- All outputs are registered and change on the same edge as the state register.
- Reset (while `rst` high):
  - state=RESET_PLL, cnt=0, retry_cnt=0.
  - pll_rst=1, core_rst=1, ready=0, lock_err=0.
- Output decode per state:
  - RESET_PLL: pll_rst=1, core_rst=1.
  - WAIT_LOCK and STABLE: pll_rst=0, core_rst=1.
  - RUN: pll_rst=0, core_rst=0, ready=1.
  - ERROR: pll_rst=0, core_rst=1, lock_err=1.
- RESET_PLL: cnt increments each cycle. At cnt==RST_PULSE-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_PULSE cycles after entry.
- WAIT_LOCK:
  - locked_s=1: go to STABLE.
  - Else at cnt==LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRIES, go to ERROR;
    - otherwise retry_cnt+1 and go to RESET_PLL.
  - When lock and timeout coincide, lock wins.
- STABLE:
  - locked_s=0: go back to WAIT_LOCK. The timeout window restarts and no retry is consumed.
  - Else at cnt==LOCK_STABLE-1: go to RUN and clear retry_cnt to 0.
- RUN: locked_s=0 goes to RESET_PLL with retry_cnt=0. core_rst rises and ready falls on that same edge.
- ERROR: stays in ERROR until relock_req.
- relock_req (any state, including RUN and ERROR):
  - next state RESET_PLL, cnt=0, retry_cnt=0.
  - lock_err clears on the same edge.
  - A relock_req while already in RESET_PLL restarts the pulse from cnt=0.
  - relock_req has priority over every other transition in the same cycle.
- `rst` has priority over everything. Asserting it mid-sequence, including in RUN, returns to the reset values on the next edge.
- Latency:
  - Let `locked` be first sampled high at edge k.
  - locked_s=1 after edge k+1; STABLE is entered at edge k+2; RUN is entered at edge k+1+LOCK_STABLE+1.
  - With LOCK_STABLE=8, RUN is entered at k+10.
- No combinational path from any input to any output.

Test Plan:
(Bench parameters: RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.)
- Power-up lock: release rst, raise locked 10 cycles later.
  - Required: pll_rst high exactly 4 cycles after release.
  - Required: ready and core_rst=0 toggle exactly 10 edges after locked is first sampled; retry_cnt=0.
- Lock glitch in STABLE: drop locked for 3 cycles midway through STABLE.
  - Required: state returns to WAIT_LOCK with no pll_rst pulse and retry_cnt unchanged.
  - Required: ready 10 edges after locked is re-sampled high.
- Timeout/retry: hold locked=0.
  - Required: 3 pll_rst pulses of 4 cycles each, spaced 36 cycles apart; retry_cnt goes 0 to 1 to 2.
  - Required: ERROR entered 32 cycles after the third pulse ends; lock_err=1, core_rst=1.
- Recovery from ERROR: in ERROR pulse relock_req with locked=1.
  - Required: lock_err=0 and pll_rst=1 on the next edge, retry_cnt=0, then RUN.
- Lock loss in RUN: drop locked while ready=1.
  - Required: 2 edges later core_rst=1, ready=0, pll_rst=1 for 4 cycles, then a normal re-lock.
- Simultaneous events and reset:
  - Raise locked_s on the timeout cycle: required STABLE, no retry.
  - relock_req in the cycle RUN would be entered: required RESET_PLL.
  - Assert rst in RUN: required reset values on the next edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Sequences reset and lock bring-up of the core PLL. The block pulses the PLL
// reset, waits for the synchronized lock indicator to stay high for a run of
// cycles, then releases the downstream core reset. On lock timeout the PLL is
// retried a bounded number of times before a sticky error is reported.
// Lock loss in RUN or a host re-lock request restarts the whole sequence.
// Everything runs in the free-running reference clock domain.
//
// Ports:
//   refclk_i      free-running reference clock
//   rst_i         synchronous active-high reset (highest priority)
//   locked_i      PLL lock indicator, asynchronous to refclk_i
//   relock_req_i  single-cycle request to re-run the full sequence
//   pll_rst_o     reset to the PLL
//   core_rst_o    active-high reset to PLL-clocked logic
//   ready_o       high only in RUN
//   lock_err_o    high only in ERROR
//   retry_cnt_o   retries used in the current sequence
//   state_dbg_o   RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, ERROR=4
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE    = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  input  logic       relock_req_i,
  output logic       pll_rst_o,
  output logic       core_rst_o,
  output logic       ready_o,
  output logic       lock_err_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_dbg_o
);

  localparam int unsigned CNT_MAX_A = (RST_PULSE > LOCK_STABLE) ? RST_PULSE : LOCK_STABLE;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX);

  // Terminal counts, one cycle early because the transition happens on the
  // edge that would otherwise advance the counter to the full count.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_ERROR     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             restart_s;
  logic             sync1_q, locked_s_q;
  logic             pll_rst_q, pll_rst_d;
  logic             core_rst_q, core_rst_d;
  logic             ready_q, ready_d;
  logic             lock_err_q, lock_err_d;

  // Two-flop synchronizer bringing the asynchronous lock flag into refclk.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= locked_i;
      locked_s_q <= sync1_q;
    end
  end

  // Next-state, retry bookkeeping and shared counter.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    restart_s = 1'b0;
    cnt_d     = cnt_q;

    if (relock_req_i) begin
      // Re-lock overrides every other transition, and also restarts an
      // in-progress reset pulse even though the state itself is unchanged.
      state_d   = ST_RESET_PLL;
      retry_d   = 4'd0;
      restart_s = 1'b1;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            state_d = ST_RESET_PLL;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is tested first so it wins over a coinciding timeout.
          if (locked_s_q) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_RESET_PLL;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          // A glitch only restarts the lock wait; it does not cost a retry.
          if (!locked_s_q) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = 4'd0;
          end else begin
            state_d = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!locked_s_q) begin
            state_d = ST_RESET_PLL;
            retry_d = 4'd0;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_RESET_PLL;
          retry_d = 4'd0;
        end
      endcase
    end

    // The counter only matters in the timed states; it is parked at zero in
    // RUN and ERROR so it can never wrap there.
    if (restart_s || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RESET_PLL) || (state_q == ST_WAIT_LOCK) ||
                 (state_q == ST_STABLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Output decode from the next state so the registered outputs change on the
  // same edge as the state register.
  always_comb begin
    pll_rst_d  = 1'b0;
    core_rst_d = 1'b1;
    ready_d    = 1'b0;
    lock_err_d = 1'b0;
    case (state_d)
      ST_RESET_PLL: begin
        pll_rst_d  = 1'b1;
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        core_rst_d = 1'b1;
      end
      ST_RUN: begin
        core_rst_d = 1'b0;
        ready_d    = 1'b1;
      end
      ST_ERROR: begin
        lock_err_d = 1'b1;
      end
      default: begin
        pll_rst_d  = 1'b1;
      end
    endcase
  end

  // State, counter, retry and output registers.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q    <= ST_RESET_PLL;
      cnt_q      <= '0;
      retry_q    <= 4'd0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pll_rst_q  <= pll_rst_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign core_rst_o  = core_rst_q;
  assign ready_o     = ready_q;
  assign lock_err_o  = lock_err_q;
  assign retry_cnt_o = retry_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for pll_lock_sequencer: directed scenarios with hand-computed cycle
// expectations, then randomized lock/relock/reset traffic, all compared every
// cycle against a phase/age reference model of the sequencing rules.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int TO = 32;
  localparam int MR = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, core_rst, ready, lock_err;
  logic [3:0] retry_cnt;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  pll_lock_sequencer #(
    .RST_PULSE(RP), .LOCK_STABLE(LS), .LOCK_TIMEOUT(TO), .MAX_RETRIES(MR)
  ) dut (
    .refclk_i(refclk), .rst_i(rst), .locked_i(locked), .relock_req_i(relock_req),
    .pll_rst_o(pll_rst), .core_rst_o(core_rst), .ready_o(ready),
    .lock_err_o(lock_err), .retry_cnt_o(retry_cnt), .state_dbg_o(state_dbg)
  );

  initial forever #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  // Reference model: phase number (0 reset pulse, 1 waiting, 2 stable,
  // 3 run, 4 error), cycles spent in the phase, retries used.
  typedef struct packed {
    int ph;
    int age;
    int rt;
  } mstate_t;

  mstate_t m = '0;
  bit      m_h1 = 1'b0;
  bit      m_h2 = 1'b0;

  function automatic mstate_t model_next(input mstate_t s, input bit rq, input bit ls);
    mstate_t n;
    int nph;
    n   = s;
    nph = s.ph;
    if (rq) begin
      n.ph = 0; n.age = 0; n.rt = 0;
      return n;
    end
    case (s.ph)
      0: nph = (s.age == RP - 1) ? 1 : 0;
      1: begin
        if (ls) nph = 2;
        else if (s.age == TO - 1) begin
          if (s.rt == MR) nph = 4;
          else begin n.rt = s.rt + 1; nph = 0; end
        end
      end
      2: begin
        if (!ls) nph = 1;
        else if (s.age == LS - 1) begin nph = 3; n.rt = 0; end
      end
      3: if (!ls) begin nph = 0; n.rt = 0; end
      default: nph = 4;
    endcase
    n.age = (nph != s.ph) ? 0 : s.age + 1;
    n.ph  = nph;
    return n;
  endfunction

  function automatic logic [10:0] model_outputs(input mstate_t s);
    logic [3:0] r;
    logic [2:0] p;
    r = 4'(s.rt);
    p = 3'(s.ph);
    return {s.ph == 0, s.ph != 3, s.ph == 3, s.ph == 4, r, p};
  endfunction

  initial forever begin
    @(posedge refclk);
    if (rst) begin
      m      <= '0;
      m_h1   <= 1'b0;
      m_h2   <= 1'b0;
      chk_en <= 1'b1;
    end else begin
      m    <= model_next(m, relock_req, m_h2);
      m_h1 <= locked;
      m_h2 <= m_h1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge refclk);
    if (chk_en) begin
      check($sformatf("outputs@cyc%0d", cyc),
            {21'd0, pll_rst, core_rst, ready, lock_err, retry_cnt, state_dbg},
            {21'd0, model_outputs(m)});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"}, pll_rst, 1);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_lock_err"}, lock_err, 0);
    check({tag, "_retry"}, retry_cnt, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    int t0, t1, w, nr, nf, err_at, core_at, run_left;
    bit saw_pll, saw_wait, prev_pll;
    int rise[4];
    int fall[4];
    int rise_rt[4];

    // Reset values.
    tick(3);
    check_reset_values("reset");

    // Power-up: pulse length, then lock 10 cycles after release.
    rst = 1'b0;
    w = 0;
    while (pll_rst === 1'b1 && w < 20) begin w++; tick(1); end
    check("pwrup_pll_rst_cycles", w, 4);
    tick(6);
    locked = 1'b1;
    t0 = cyc;
    wait_ready();
    check("pwrup_ready_latency", cyc - t0, 11);
    check("pwrup_core_rst", core_rst, 0);
    check("pwrup_retry", retry_cnt, 0);

    // Lock glitch in STABLE after a relock from RUN.
    tick(2);
    relock_req = 1'b1;
    t0 = cyc;
    tick(1);
    relock_req = 1'b0;
    check("relock_pll_rst", pll_rst, 1);
    check("relock_ready_drop", ready, 0);
    tick(8);
    locked = 1'b0;
    saw_pll = 1'b0;
    saw_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (pll_rst === 1'b1) saw_pll = 1'b1;
      if (state_dbg === 3'd1) saw_wait = 1'b1;
    end
    locked = 1'b1;
    t1 = cyc;
    w = 0;
    while (ready !== 1'b1 && w < 300) begin
      tick(1);
      w++;
      if (pll_rst === 1'b1) saw_pll = 1'b1;
      if (state_dbg === 3'd1) saw_wait = 1'b1;
    end
    check("glitch_ready_latency", cyc - t1, 11);
    check("glitch_back_to_wait", saw_wait, 1);
    check("glitch_no_pll_rst", saw_pll, 0);
    check("glitch_retry", retry_cnt, 0);

    // Lock loss in RUN, then permanent timeout: retries and ERROR.
    tick(3);
    locked = 1'b0;
    t0 = cyc;
    nr = 0; nf = 0; err_at = -1; core_at = -1;
    prev_pll = pll_rst;
    for (int i = 0; i < 200 && err_at < 0; i++) begin
      tick(1);
      if (core_at < 0 && core_rst === 1'b1) core_at = cyc;
      if (pll_rst === 1'b1 && !prev_pll && nr < 4) begin
        rise[nr] = cyc; rise_rt[nr] = int'(retry_cnt); nr++;
      end
      if (pll_rst === 1'b0 && prev_pll && nf < 4) begin
        fall[nf] = cyc; nf++;
      end
      prev_pll = (pll_rst === 1'b1);
      if (lock_err === 1'b1) err_at = cyc;
    end
    check("loss_core_rst_latency", core_at - t0, 3);
    check("retry_pulse_count", nr, 3);
    check("retry_fall_count", nf, 3);
    if (nr == 3 && nf == 3) begin
      check("loss_first_pulse", rise[0] - t0, 3);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("pulse%0d_width", i), fall[i] - rise[i], 4);
        check($sformatf("pulse%0d_retry", i), rise_rt[i], i);
      end
      check("pulse_spacing_01", rise[1] - rise[0], 36);
      check("pulse_spacing_12", rise[2] - rise[1], 36);
      check("error_after_last_pulse", err_at - fall[2], 32);
    end
    tick(5);
    check("error_lock_err", lock_err, 1);
    check("error_core_rst", core_rst, 1);
    check("error_ready", ready, 0);

    // Recovery from ERROR via relock_req with lock present.
    locked = 1'b1;
    tick(3);
    relock_req = 1'b1;
    t0 = cyc;
    tick(1);
    relock_req = 1'b0;
    check("recover_lock_err", lock_err, 0);
    check("recover_pll_rst", pll_rst, 1);
    check("recover_retry", retry_cnt, 0);
    wait_ready();
    check("recover_ready_at", cyc - t0, 14);

    // Lock arrives on exactly the timeout cycle.
    tick(2);
    locked = 1'b0;
    t0 = cyc;
    tick(36);
    locked = 1'b1;
    tick(2);
    check("tmo_still_waiting", state_dbg, 1);
    tick(1);
    check("tmo_lock_wins_state", state_dbg, 2);
    check("tmo_lock_wins_retry", retry_cnt, 0);

    // relock_req on the cycle RUN would be entered.
    tick(7);
    relock_req = 1'b1;
    t1 = cyc;
    tick(1);
    relock_req = 1'b0;
    check("relock_vs_run_state", state_dbg, 0);
    check("relock_vs_run_ready", ready, 0);
    check("relock_vs_run_pll", pll_rst, 1);
    wait_ready();
    check("relock_vs_run_ready_at", cyc - t1, 14);

    // rst asserted in RUN.
    tick(3);
    rst = 1'b1;
    tick(1);
    check_reset_values("rst_in_run");
    tick(1);
    rst = 1'b0;

    // Randomized lock behaviour with occasional relock and reset.
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        locked = ($urandom_range(0, 2) != 0);
        run_left = $urandom_range(1, 150);
      end
      run_left--;
      relock_req = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 699) == 0);
      tick(1);
    end
    rst = 1'b0;
    relock_req = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
